// File: rtl/fp_lshift_normalizer.sv
// Two-stage post-add normalizer: count leading zeros, then left-shift the mantissa and
// decrement the exponent, clamping to a denormal when the exponent runs out.
module fp_lshift_normalizer #(
  parameter int unsigned MANT_W = 32,
  parameter int unsigned EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_denorm,
  output logic [5:0]        out_shamt
);

  logic              s1_valid;
  logic [MANT_W-1:0] s1_mant;
  logic [EXP_W-1:0]  s1_exp;
  logic [5:0]        s1_lzc;
  logic              s1_zero;
  logic              s2_valid;

  logic              s1_adv;
  logic              s2_adv;
  logic [5:0]        lzc;
  logic              found;

  logic [EXP_W:0]    exp_ext;
  logic [EXP_W:0]    lzc_ext;
  logic [5:0]        shamt_d;
  logic [MANT_W-1:0] mant_d;
  logic [EXP_W-1:0]  exp_d;
  logic              zero_d;
  logic              denorm_d;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_comb begin
    lzc   = 6'(MANT_W);
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && in_mant[i]) begin
        lzc   = 6'(MANT_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  // One extra exponent bit keeps the compare/subtract from wrapping.
  always_comb begin
    exp_ext  = {1'b0, s1_exp};
    lzc_ext  = (EXP_W + 1)'(s1_lzc);
    shamt_d  = '0;
    exp_d    = '0;
    zero_d   = 1'b0;
    denorm_d = 1'b0;
    if (s1_zero) begin
      zero_d = 1'b1;
    end else if (lzc_ext <= exp_ext) begin
      shamt_d = s1_lzc;
      exp_d   = EXP_W'(exp_ext - lzc_ext);
    end else begin
      shamt_d  = 6'(s1_exp);
      denorm_d = 1'b1;
    end
    mant_d = s1_mant << shamt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant <= in_mant;
        s1_exp  <= in_exp;
        s1_lzc  <= lzc;
        s1_zero <= (in_mant == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
      out_shamt  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant   <= mant_d;
        out_exp    <= exp_d;
        out_zero   <= zero_d;
        out_denorm <= denorm_d;
        out_shamt  <= shamt_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_lshift_normalizer.sv
// Scoreboard bench: the driver queues hand-computed results, the monitor checks each output beat.
module tb_fp_lshift_normalizer;

  typedef struct packed {
    logic [31:0] m;
    logic [7:0]  e;
    logic        z;
    logic        d;
    logic [5:0]  s;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_denorm;
  logic [5:0]  out_shamt;

  int   tests = 0;
  int   fails = 0;
  int   accepted = 0;
  int   popped = 0;
  res_t sb[$];

  fp_lshift_normalizer #(.MANT_W(32), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero),
    .out_denorm(out_denorm), .out_shamt(out_shamt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [31:0] m, input logic [7:0] e, input res_t r);
    bit ok = 0;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(r);
        accepted++;
        ok = 1;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic res_t mk(input logic [31:0] m, input logic [7:0] e, input logic z,
                              input logic d, input logic [5:0] s);
    res_t r;
    r.m = m; r.e = e; r.z = z; r.d = d; r.s = s;
    return r;
  endfunction

  // Monitor: every presented beat must match the queue head; pop only on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: out_valid=1 with nothing outstanding, required 0");
      end else begin
        check("out_beat", {24'h0, out_mant, out_exp}, {24'h0, sb[0].m, sb[0].e});
        check("out_flags", {61'h0, out_zero, out_denorm, 1'b0} | 64'(out_shamt) << 8,
              {61'h0, sb[0].z, sb[0].d, 1'b0} | 64'(sb[0].s) << 8);
        if (out_ready) begin
          void'(sb.pop_front());
          popped++;
        end
      end
    end
  end

  initial begin
    int base;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_data", {out_mant, out_exp, out_zero, out_denorm, out_shamt}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accepted at one edge, visible after the next.
    send(32'h0000_1000, 8'd100, mk(32'h8000_0000, 8'd81, 0, 0, 6'd19));
    check("latency_s1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_s2", 64'(out_valid), 64'd1);

    send(32'h8000_0001, 8'd5,   mk(32'h8000_0001, 8'd5,   0, 0, 6'd0));
    send(32'h0000_0000, 8'd77,  mk(32'h0000_0000, 8'd0,   1, 0, 6'd0));
    send(32'h0000_00F0, 8'd3,   mk(32'h0000_0780, 8'd0,   0, 1, 6'd3));
    send(32'h0000_0001, 8'd31,  mk(32'h8000_0000, 8'd0,   0, 0, 6'd31));
    send(32'h0000_0001, 8'd30,  mk(32'h4000_0000, 8'd0,   0, 1, 6'd30));
    send(32'h0000_0100, 8'd255, mk(32'h8000_0000, 8'd232, 0, 0, 6'd23));
    repeat (4) @(posedge clk); #1;
    check("drain_basic", 64'(sb.size()), 64'd0);

    // Backpressure: 5 beats against a stalled sink.
    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        send(32'h0000_0003, 8'd200, mk(32'hC000_0000, 8'd170, 0, 0, 6'd30));
        send(32'h00FF_0000, 8'd10,  mk(32'hFF00_0000, 8'd2,   0, 0, 6'd8));
        send(32'h4000_0000, 8'd0,   mk(32'h4000_0000, 8'd0,   0, 1, 6'd0));
        send(32'h0001_0000, 8'd16,  mk(32'h8000_0000, 8'd1,   0, 0, 6'd15));
        send(32'hFFFF_FFFF, 8'd255, mk(32'hFFFF_FFFF, 8'd255, 0, 0, 6'd0));
      end
      begin
        repeat (8) @(posedge clk); #1;
        check("bp_accepted", 64'(accepted), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        base = popped;
        repeat (5) @(posedge clk);
        #1;
        check("bp_throughput", 64'(popped - base), 64'd5);
      end
    join
    repeat (3) @(posedge clk); #1;
    check("drain_bp", 64'(sb.size()), 64'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(32'h0000_0010, 8'd50, mk(32'h8000_0000, 8'd23, 0, 0, 6'd27));
    send(32'h0000_0020, 8'd50, mk(32'h8000_0000, 8'd24, 0, 0, 6'd26));
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data", {out_mant, out_exp, out_zero, out_denorm, out_shamt}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("no_stale", 64'(out_valid), 64'd0);

    send(32'h0000_0002, 8'd40, mk(32'h8000_0000, 8'd10, 0, 0, 6'd30));
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    #1;
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
